// File: rtl/irq_pkg.sv
// Shared types and helpers for the nested interrupt controller.
// Feature macro used by the top: IRQ_NEST_EN (preemption by higher levels).
package irq_pkg;

  localparam int unsigned MaxIrq = 16;
  localparam int unsigned IdxW   = $clog2(MaxIrq);

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } irq_state_e;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
  } prio_t;

  // Highest set bit wins; idx is meaningless when valid is low.
  function automatic prio_t prio_idx(input logic [MaxIrq-1:0] mask);
    prio_t res;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < MaxIrq; i++) begin
      if (mask[i]) begin
        res.valid = 1'b1;
        res.idx   = IdxW'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational highest-set-bit encoder, NumIrq wide.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NumIrq = 3
) (
  input  logic [NumIrq-1:0] mask_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [MaxIrq-1:0] mask_wide;
  prio_t             res;

  assign mask_wide = MaxIrq'(mask_i);
  assign res       = prio_idx(mask_wide);
  assign valid_o   = res.valid;
  assign idx_o     = res.idx;

endmodule

// File: rtl/irq_priority_ctrl.sv
// N-channel nested interrupt controller: edge capture, fixed priority, req/ack to the core.
// Preemption by higher channels is enabled only when IRQ_NEST_EN is defined.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned     NUM_IRQ    = 3,
  parameter int unsigned     VEC_W      = 32,
  parameter logic [VEC_W-1:0] BASE_VEC   = VEC_W'(32'h0000_0100),
  parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_W'(32'h0000_0020)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               irq_ack,
  input  logic               eret,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] inter_running
);

  logic [NUM_IRQ-1:0] irq_d_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] running_q;
  irq_state_e         state_q;
  logic [IdxW-1:0]    ch_q;
  logic               req_q;
  logic [VEC_W-1:0]   vec_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] above;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_set;
  logic [NUM_IRQ-1:0] eret_clr;
  logic               ack_fire;
  logic               lvl_valid;
  logic [IdxW-1:0]    lvl_idx;
  logic               arb_valid;
  logic [IdxW-1:0]    arb_idx;
  logic [VEC_W-1:0]   vec_next;

  irq_prio_enc #(
    .NumIrq (NUM_IRQ)
  ) u_lvl_enc (
    .mask_i  (running_q),
    .valid_o (lvl_valid),
    .idx_o   (lvl_idx)
  );

  irq_prio_enc #(
    .NumIrq (NUM_IRQ)
  ) u_arb_enc (
    .mask_i  (eligible),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  assign rise     = irq_in & ~irq_d_q;
  assign ack_fire = (state_q == StReq) && irq_ack;
  assign eligible = pending_q & irq_en & above;
  assign vec_next = BASE_VEC + VEC_W'(arb_idx) * VEC_STRIDE;

  // Only channels strictly above the current in-service level may request.
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef IRQ_NEST_EN
      above[i] = !lvl_valid || (int'(lvl_idx) < i);
`else
      above[i] = !lvl_valid;
`endif
    end
  end

  // eret drops the pre-update top level; ack then adds the acked channel.
  always_comb begin
    ack_set  = '0;
    eret_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_set[i]  = ack_fire && (ch_q == IdxW'(i));
      eret_clr[i] = eret && lvl_valid && (lvl_idx == IdxW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      irq_d_q   <= '0;
      pending_q <= '0;
      running_q <= '0;
    end else begin
      irq_d_q   <= irq_in;
      pending_q <= (pending_q & ~ack_set) | rise;
      running_q <= (running_q & ~eret_clr) | ack_set;
    end
  end

  // Once presented, a request is held until ack regardless of later changes.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      ch_q    <= '0;
      req_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            ch_q    <= arb_idx;
            vec_q   <= vec_next;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (irq_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign irq_req       = req_q;
  assign irq_vec       = vec_q;
  assign irq_pending   = pending_q;
  assign inter_running = running_q;

endmodule
